beams_pwr_sort: RTL and testbench

- Produces the sorted-beam descriptor stream consumed by the beam-pick datapath: o_sort_idx, o_sort_pwr, o_sort_sop and o_rbg_load.
- Receives per-beam powers for one RBG, one beam per cycle, and maintains a running top-16 list by single-cycle parallel insertion.
- At end of RBG, publishes the 16 strongest beam indices and powers in descending order.

---
 rtl/beams_pwr_sort.sv | 279 +++++++++++++++++++++++++++
 tb/tb_beams_pwr_sort.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beams_pwr_sort.sv
// ---------------------------------------------------------------------------
// beams_pwr_sort
//
// Collects per-beam powers for one RBG, one beam per cycle, and keeps a
// running top-16 list sorted in descending power. Each accepted beam is
// inserted in a single cycle by comparing it against all 16 slots in
// parallel. At the end of the RBG the list is snapshotted and published
// on o_sort_pwr / o_sort_idx together with a one-cycle o_sort_sop /
// o_rbg_load pulse.
//
// Ports:
//   i_clk        clock
//   i_reset_n    asynchronous active-low reset (assert async, release sync)
//   i_pwr_vld    beam power beat valid
//   i_pwr_sop    first beam of RBG (qualified by i_pwr_vld)
//   i_pwr_eop    last beam of RBG (qualified by i_pwr_vld)
//   i_beam_pwr   unsigned beam power
//   o_sort_pwr   16 sorted powers, slot 0 = largest, empty slot = 0
//   o_sort_idx   16 beam indices matching o_sort_pwr, empty slot = 8'hFF
//   o_sort_sop   one-cycle pulse: new list valid
//   o_rbg_load   one-cycle pulse, coincident with o_sort_sop
//   o_err        one-cycle protocol-error pulse
//
// Build option:
//   BEAMS_PWR_SORT_OUTREG_EN  when defined, adds one more register stage on
//                             every output (o_err included), so a publish
//                             appears 2 cycles after the eop beat instead
//                             of 1. Reset values are the same either way.
// ---------------------------------------------------------------------------
module beams_pwr_sort #(
  parameter int PWR_WIDTH = 32,
  parameter int NUM_BEAMS = 64
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_pwr_vld,
  input  logic                        i_pwr_sop,
  input  logic                        i_pwr_eop,
  input  logic [PWR_WIDTH-1:0]        i_beam_pwr,
  output logic [15:0][PWR_WIDTH-1:0]  o_sort_pwr,
  output logic [15:0][7:0]            o_sort_idx,
  output logic                        o_sort_sop,
  output logic                        o_rbg_load,
  output logic                        o_err
);

  localparam int SLOTS = 16;
  // Counter must reach NUM_BEAMS itself (up to 256), hence 9 bits.
  localparam int CW = 9;
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM_BEAMS);
  localparam logic [7:0] IDX_EMPTY = 8'hFF;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [0:0]           state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;

  // Working list. A separate valid bit marks occupied slots because index
  // 8'hFF is a legal beam index when NUM_BEAMS = 256.
  logic [PWR_WIDTH-1:0] work_pwr_reg  [SLOTS];
  logic [PWR_WIDTH-1:0] work_pwr_next [SLOTS];
  logic [7:0]           work_idx_reg  [SLOTS];
  logic [7:0]           work_idx_next [SLOTS];
  logic [SLOTS-1:0]     work_vld_reg, work_vld_next;

  // Published snapshot (first output stage).
  logic [PWR_WIDTH-1:0] pub_pwr_reg [SLOTS];
  logic [7:0]           pub_idx_reg [SLOTS];
  logic                 pub_sop_reg;
  logic                 err_reg;

  // -------------------------------------------------------------------------
  // Beat decode
  // -------------------------------------------------------------------------
  logic       beat_start;   // sop beat, accepted in any state
  logic       beat_cont;    // non-sop beat while accumulating
  logic       beat_room;    // fewer than NUM_BEAMS beams taken so far
  logic       beat_ins;     // beat is inserted into the list
  logic       beat_pub;     // beat ends the RBG and triggers a publish
  logic       beat_err;     // protocol violation on this beat
  logic [7:0] beat_idx;     // index assigned to this beat

  always_comb begin
    beat_start = i_pwr_vld & i_pwr_sop;
    beat_cont  = i_pwr_vld & ~i_pwr_sop & (state_reg == ST_ACC);
    beat_room  = (cnt_reg < CNT_MAX);
    beat_ins   = beat_start | (beat_cont & beat_room);
    // An over-length eop beat is not inserted but still closes the RBG.
    beat_pub   = i_pwr_eop & (beat_start | beat_cont);
    beat_err   = i_pwr_vld & (
                   (~i_pwr_sop & (state_reg == ST_IDLE)) |
                   ( i_pwr_sop & (state_reg == ST_ACC))  |
                   (beat_cont & ~beat_room));
    // cnt_reg < 256 whenever the beat is inserted, so 8 bits suffice.
    beat_idx   = beat_start ? 8'd0 : cnt_reg[7:0];
  end

  // -------------------------------------------------------------------------
  // Parallel insertion
  //
  // The base list is the working list, or an empty list on a sop beat so
  // that a new RBG (or a restart) never sees stale entries. Because the list
  // is kept in descending order with empty slots at the bottom, the gt
  // vector is thermometer-shaped (once set it stays set towards slot 15).
  // The insertion point is therefore the first set bit, every slot below it
  // takes its upper neighbour, and slot 15 falls off the end. The strict
  // compare places an equal-power beam after the existing one, so earlier
  // indices win ties.
  // -------------------------------------------------------------------------
  logic [PWR_WIDTH-1:0] base_pwr [SLOTS];
  logic [7:0]           base_idx [SLOTS];
  logic [SLOTS-1:0]     base_vld;
  logic [SLOTS-1:0]     gt;

  logic [PWR_WIDTH-1:0] ins_pwr [SLOTS];
  logic [7:0]           ins_idx [SLOTS];
  logic [SLOTS-1:0]     ins_vld;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_base
      assign base_pwr[gi] = beat_start ? '0 : work_pwr_reg[gi];
      assign base_idx[gi] = beat_start ? IDX_EMPTY : work_idx_reg[gi];
      assign base_vld[gi] = ~beat_start & work_vld_reg[gi];
      assign gt[gi]       = ~base_vld[gi] | (i_beam_pwr > base_pwr[gi]);
    end

    for (gi = 0; gi < SLOTS; gi++) begin : g_ins
      if (gi == 0) begin : g_top
        always_comb begin
          if (gt[0]) begin
            ins_pwr[0] = i_beam_pwr;
            ins_idx[0] = beat_idx;
            ins_vld[0] = 1'b1;
          end else begin
            ins_pwr[0] = base_pwr[0];
            ins_idx[0] = base_idx[0];
            ins_vld[0] = base_vld[0];
          end
        end
      end else begin : g_rest
        always_comb begin
          if (gt[gi] & ~gt[gi-1]) begin
            // This slot is the insertion point.
            ins_pwr[gi] = i_beam_pwr;
            ins_idx[gi] = beat_idx;
            ins_vld[gi] = 1'b1;
          end else if (gt[gi]) begin
            // Below the insertion point: shift down by one.
            ins_pwr[gi] = base_pwr[gi-1];
            ins_idx[gi] = base_idx[gi-1];
            ins_vld[gi] = base_vld[gi-1];
          end else begin
            ins_pwr[gi] = base_pwr[gi];
            ins_idx[gi] = base_idx[gi];
            ins_vld[gi] = base_vld[gi];
          end
        end
      end
    end

    for (gi = 0; gi < SLOTS; gi++) begin : g_next
      assign work_pwr_next[gi] = beat_ins ? ins_pwr[gi] : work_pwr_reg[gi];
      assign work_idx_next[gi] = beat_ins ? ins_idx[gi] : work_idx_reg[gi];
      assign work_vld_next[gi] = beat_ins ? ins_vld[gi] : work_vld_reg[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Control next-state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (beat_pub) begin
      state_next = ST_IDLE;
    end else if (beat_start) begin
      state_next = ST_ACC;
    end

    cnt_next = cnt_reg;
    if (beat_start) begin
      cnt_next = CW'(1);
    end else if (beat_cont & beat_room) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      work_vld_reg <= '0;
      pub_sop_reg  <= 1'b0;
      err_reg      <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        work_pwr_reg[k] <= '0;
        work_idx_reg[k] <= IDX_EMPTY;
        pub_pwr_reg[k]  <= '0;
        pub_idx_reg[k]  <= IDX_EMPTY;
      end
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      work_vld_reg <= work_vld_next;
      pub_sop_reg  <= beat_pub;
      err_reg      <= beat_err;
      for (int k = 0; k < SLOTS; k++) begin
        work_pwr_reg[k] <= work_pwr_next[k];
        work_idx_reg[k] <= work_idx_next[k];
      end
      // Snapshot includes the eop beam itself; empty slots already carry
      // pwr 0 / idx 8'hFF. The snapshot holds until the next publish.
      if (beat_pub) begin
        for (int k = 0; k < SLOTS; k++) begin
          pub_pwr_reg[k] <= work_pwr_next[k];
          pub_idx_reg[k] <= work_idx_next[k];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
`ifdef BEAMS_PWR_SORT_OUTREG_EN
  logic [PWR_WIDTH-1:0] out_pwr_reg [SLOTS];
  logic [7:0]           out_idx_reg [SLOTS];
  logic                 out_sop_reg;
  logic                 out_err_reg;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_sop_reg <= 1'b0;
      out_err_reg <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        out_pwr_reg[k] <= '0;
        out_idx_reg[k] <= IDX_EMPTY;
      end
    end else begin
      out_sop_reg <= pub_sop_reg;
      out_err_reg <= err_reg;
      for (int k = 0; k < SLOTS; k++) begin
        out_pwr_reg[k] <= pub_pwr_reg[k];
        out_idx_reg[k] <= pub_idx_reg[k];
      end
    end
  end

  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_out
      assign o_sort_pwr[gi] = out_pwr_reg[gi];
      assign o_sort_idx[gi] = out_idx_reg[gi];
    end
  endgenerate

  assign o_sort_sop = out_sop_reg;
  assign o_rbg_load = out_sop_reg;
  assign o_err      = out_err_reg;
`else
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_out
      assign o_sort_pwr[gi] = pub_pwr_reg[gi];
      assign o_sort_idx[gi] = pub_idx_reg[gi];
    end
  endgenerate

  assign o_sort_sop = pub_sop_reg;
  assign o_rbg_load = pub_sop_reg;
  assign o_err      = err_reg;
`endif

endmodule

// File: tb/tb_beams_pwr_sort.sv
// ---------------------------------------------------------------------------
// tb_beams_pwr_sort
//
// Directed-vector bench for beams_pwr_sort. Stimulus pushes the expected
// publish records and error-pulse cycles into queues; an independent
// monitor on the falling clock edge pops and compares whenever the DUT
// pulses o_sort_sop / o_rbg_load or o_err, and flags any expected event
// whose cycle has passed without being seen.
// ---------------------------------------------------------------------------
module tb_beams_pwr_sort;

`ifdef BEAMS_PWR_SORT_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              vld, sop, eop;
  logic [31:0]       pwr;
  logic [15:0][31:0] s_pwr;
  logic [15:0][7:0]  s_idx;
  logic              s_sop, s_load, s_err;

  always #5 clk = ~clk;

  beams_pwr_sort #(.PWR_WIDTH(32), .NUM_BEAMS(64)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_pwr_vld  (vld),
    .i_pwr_sop  (sop),
    .i_pwr_eop  (eop),
    .i_beam_pwr (pwr),
    .o_sort_pwr (s_pwr),
    .o_sort_idx (s_idx),
    .o_sort_sop (s_sop),
    .o_rbg_load (s_load),
    .o_err      (s_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [15:0][31:0] pwr;
    logic [15:0][7:0]  idx;
  } pub_t;

  pub_t pub_q[$];
  int   err_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic pub_t blank(input int c);
    pub_t e;
    e.cyc = c;
    for (int k = 0; k < 16; k++) begin
      e.pwr[k] = 32'd0;
      e.idx[k] = 8'hFF;
    end
    return e;
  endfunction

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    pub_t e;
    while (pub_q.size() > 0 && pub_q[0].cyc < cyc) begin
      e = pub_q.pop_front();
      chk("missing_publish_cycle", 512'(cyc), 512'(e.cyc));
    end
    while (err_q.size() > 0 && err_q[0] < cyc) begin
      chk("missing_err_cycle", 512'(cyc), 512'(err_q.pop_front()));
    end
    if (s_sop || s_load) begin
      if (pub_q.size() == 0) begin
        chk("unexpected_publish", {510'd0, s_sop, s_load}, 512'd0);
      end else begin
        e = pub_q.pop_front();
        $display("publish cyc=%0d slot0 idx=%0d pwr=%0d", cyc, s_idx[0], s_pwr[0]);
        chk("publish_cycle", 512'(cyc), 512'(e.cyc));
        chk("sop_and_load", {510'd0, s_sop, s_load}, 512'd3);
        chk("sort_pwr", s_pwr, e.pwr);
        chk("sort_idx", 512'(s_idx), 512'(e.idx));
      end
    end
    if (s_err) begin
      if (err_q.size() == 0) begin
        chk("unexpected_err", 512'(s_err), 512'd0);
      end else begin
        $display("err pulse cyc=%0d", cyc);
        chk("err_cycle", 512'(cyc), 512'(err_q.pop_front()));
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic beat(input logic s, input logic e, input logic [31:0] p, output int c);
    @(negedge clk);
    vld = 1'b1; sop = s; eop = e; pwr = p;
    c = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld = 1'b0; sop = 1'b0; eop = 1'b0; pwr = '0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [15:0][7:0] ff_idx;
    for (int k = 0; k < 16; k++) ff_idx[k] = 8'hFF;
    chk({tag, "_pwr"}, s_pwr, 512'd0);
    chk({tag, "_idx"}, 512'(s_idx), 512'(ff_idx));
    chk({tag, "_pulses"}, {509'd0, s_sop, s_load, s_err}, 512'd0);
  endtask

  task automatic run_ramp64();
    pub_t e;
    int   c;
    for (int i = 0; i < 64; i++) begin
      beat(i == 0, i == 63, 32'(i * 10), c);
    end
    e = blank(c + LAT);
    for (int k = 0; k < 16; k++) begin
      e.idx[k] = 8'(63 - k);
      e.pwr[k] = 32'((63 - k) * 10);
    end
    pub_q.push_back(e);
    idle(3);
  endtask

  initial begin
    pub_t e;
    int   c;
    int   t2_pwr [5] = '{7, 3, 9, 3, 1};
    int   t2_ei  [5] = '{2, 0, 1, 3, 4};
    int   t2_ep  [5] = '{9, 7, 3, 3, 1};

    rst_n = 1'b0; vld = 1'b0; sop = 1'b0; eop = 1'b0; pwr = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    idle(2);

    // 1: 64-beam ramp
    run_ramp64();

    // 2: five beams with a tie
    for (int i = 0; i < 5; i++) beat(i == 0, i == 4, 32'(t2_pwr[i]), c);
    e = blank(c + LAT);
    for (int k = 0; k < 5; k++) begin
      e.idx[k] = 8'(t2_ei[k]);
      e.pwr[k] = 32'(t2_ep[k]);
    end
    pub_q.push_back(e);
    idle(3);

    // 3: single-beam RBG
    beat(1'b1, 1'b1, 32'h1234, c);
    e = blank(c + LAT);
    e.idx[0] = 8'd0;
    e.pwr[0] = 32'h1234;
    pub_q.push_back(e);
    idle(3);

    // 4a: beat without sop while idle
    beat(1'b0, 1'b1, 32'd77, c);
    err_q.push_back(c + LAT);
    idle(3);

    // 4b: sop mid-RBG after 10 beats restarts the list
    for (int i = 0; i < 10; i++) beat(i == 0, 1'b0, 32'(100 + i), c);
    beat(1'b1, 1'b0, 32'd5, c);
    err_q.push_back(c + LAT);
    beat(1'b0, 1'b0, 32'd50, c);
    beat(1'b0, 1'b0, 32'd20, c);
    beat(1'b0, 1'b1, 32'd50, c);
    e = blank(c + LAT);
    e.idx[0] = 8'd1; e.pwr[0] = 32'd50;
    e.idx[1] = 8'd3; e.pwr[1] = 32'd50;
    e.idx[2] = 8'd2; e.pwr[2] = 32'd20;
    e.idx[3] = 8'd0; e.pwr[3] = 32'd5;
    pub_q.push_back(e);
    idle(3);

    // 5: 70 beats, the last 6 are over-length (and deliberately strong)
    for (int i = 0; i < 70; i++) begin
      beat(i == 0, i == 69, (i < 64) ? 32'(i * 3) : 32'(1000 + i), c);
      if (i >= 64) err_q.push_back(c + LAT);
    end
    e = blank(c + LAT);
    for (int k = 0; k < 16; k++) begin
      e.idx[k] = 8'(63 - k);
      e.pwr[k] = 32'((63 - k) * 3);
    end
    pub_q.push_back(e);
    idle(3);

    // 6: back-to-back RBGs
    beat(1'b1, 1'b0, 32'd4, c);
    beat(1'b0, 1'b0, 32'd8, c);
    beat(1'b0, 1'b1, 32'd6, c);
    e = blank(c + LAT);
    e.idx[0] = 8'd1; e.pwr[0] = 32'd8;
    e.idx[1] = 8'd2; e.pwr[1] = 32'd6;
    e.idx[2] = 8'd0; e.pwr[2] = 32'd4;
    pub_q.push_back(e);
    beat(1'b1, 1'b0, 32'd1, c);
    beat(1'b0, 1'b1, 32'd2, c);
    e = blank(c + LAT);
    e.idx[0] = 8'd1; e.pwr[0] = 32'd2;
    e.idx[1] = 8'd0; e.pwr[1] = 32'd1;
    pub_q.push_back(e);
    idle(4);

    // 7: reset after 20 beats of an unfinished RBG
    for (int i = 0; i < 20; i++) beat(i == 0, 1'b0, 32'(500 + i), c);
    @(negedge clk);
    vld = 1'b0; sop = 1'b0; eop = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rbg_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 8: ramp again after reset
    run_ramp64();

    idle(LAT + 4);
    chk("pub_queue_drained", 512'(pub_q.size()), 512'd0);
    chk("err_queue_drained", 512'(err_q.size()), 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
